// File: rtl/ll_fifo_drain_arbiter.sv
// rtl/ll_fifo_drain_arbiter.sv - round-robin, burst-bounded read engine for the shared linked-list FIFO
// Pops eligible queues into a 2-entry output buffer whose entries carry the source queue id.
module ll_fifo_drain_arbiter #(
   parameter int WIDTH     = 4,
   parameter int NUM_FIFOS = 2,
   parameter int BURST     = 2,
   parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FIFOS-1:0] en_mask,
   input  logic [NUM_FIFOS-1:0] fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data_out,
   output logic                 fifo_pop,
   output logic [SEL_WIDTH-1:0] fifo_pop_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_qid,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] total_pops
);
   localparam int BW = $clog2(BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
   localparam int EW = SEL_WIDTH + WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, STALL = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [SEL_WIDTH-1:0] cur_q_q, cur_q_d;
   logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
   logic [1:0]           buf_cnt_q, buf_cnt_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [EW-1:0]        mem_q [2];
   logic [EW-1:0]        mem_d [2];
   logic [CNT_WIDTH-1:0] total_pops_q, total_pops_d;

   logic [NUM_FIFOS-1:0] eligible;
   logic                 any_elig;
   logic                 space;
   logic                 keep_cur;
   logic                 found;
   logic                 buf_pop;
   logic [SEL_WIDTH-1:0] sel;
   logic [SEL_WIDTH-1:0] idx;

   assign eligible = ~fifo_empty & en_mask;
   assign any_elig = |eligible;
   assign space    = (buf_cnt_q < 2'd2);
   // burst_cnt of 0 means no grant is held yet, so the first grant rotates to queue 0
   assign keep_cur = eligible[cur_q_q] && (burst_cnt_q != '0) && (burst_cnt_q < BURST_MAX);

   always_comb begin
      sel   = cur_q_q;
      idx   = cur_q_q;
      found = keep_cur;
      for (int i = 1; i <= NUM_FIFOS; i++) begin
         idx = SEL_WIDTH'((int'(cur_q_q) + i) % NUM_FIFOS);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign fifo_pop     = any_elig & space & ~rst;
   assign fifo_pop_sel = fifo_pop ? sel : cur_q_q;
   assign buf_pop      = (buf_cnt_q != 2'd0) & out_ready;

   always_comb begin
      cur_q_d      = cur_q_q;
      burst_cnt_d  = burst_cnt_q;
      total_pops_d = total_pops_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_d        = mem_q;
      state_d      = IDLE;
      if (fifo_pop) begin
         mem_d[wr_ptr_q] = {sel, fifo_data_out};
         wr_ptr_d        = ~wr_ptr_q;
         total_pops_d    = total_pops_q + 1'b1;
         state_d         = SERVE;
         if ((sel == cur_q_q) && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
         end else begin
            cur_q_d     = sel;
            burst_cnt_d = BW'(1);
         end
      end else if (any_elig) begin
         state_d = STALL;
      end
      if (buf_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      buf_cnt_d = buf_cnt_q + {1'b0, fifo_pop} - {1'b0, buf_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_q_q      <= SEL_WIDTH'(NUM_FIFOS - 1);
         burst_cnt_q  <= '0;
         buf_cnt_q    <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
         total_pops_q <= '0;
      end else begin
         state_q      <= state_d;
         cur_q_q      <= cur_q_d;
         burst_cnt_q  <= burst_cnt_d;
         buf_cnt_q    <= buf_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         mem_q        <= mem_d;
         total_pops_q <= total_pops_d;
      end
   end

   assign out_valid           = (buf_cnt_q != 2'd0);
   assign {out_qid, out_data} = mem_q[rd_ptr_q];
   assign state               = state_q;
   assign total_pops          = total_pops_q;
endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// tb/tb_ll_fifo_drain_arbiter.sv - self-checking bench for ll_fifo_drain_arbiter
// Shared FIFO and arbiter behaviour are modelled with arrays and queues, checked every cycle.
module tb_ll_fifo_drain_arbiter;
   localparam int WIDTH = 4;
   localparam int NQ    = 2;
   localparam int BURST = 2;
   localparam int SW    = 1;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NQ-1:0] en_mask = '1;
   logic [NQ-1:0] fifo_empty;
   logic [WIDTH-1:0] fifo_data_out;
   logic          fifo_pop;
   logic [SW-1:0] fifo_pop_sel;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [SW-1:0] out_qid;
   logic [1:0]    state;
   logic [CW-1:0] total_pops;

   int tests_run = 0;
   int tests_failed = 0;

   ll_fifo_drain_arbiter #(.WIDTH(WIDTH), .NUM_FIFOS(NQ), .BURST(BURST), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .en_mask(en_mask), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
      .fifo_pop(fifo_pop), .fifo_pop_sel(fifo_pop_sel), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_qid(out_qid), .state(state), .total_pops(total_pops));

   always #5 clk = ~clk;

   // shared FIFO: per-queue circular store, 8-bit pointers wrap naturally
   logic [WIDTH-1:0] sm [NQ][256];
   logic [7:0]       head [NQ];
   logic [7:0]       tail [NQ];

   always_comb begin
      for (int q = 0; q < NQ; q++) fifo_empty[q] = (head[q] == tail[q]);
      fifo_data_out = sm[fifo_pop_sel][head[fifo_pop_sel]];
   end

   // reference model
   int m_cur, m_burst, m_total, m_state;
   logic [SW+WIDTH-1:0] m_buf [$];
   int sel_log [$];
   logic [SW+WIDTH-1:0] acc_log [$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_cur = NQ - 1;
      m_burst = 0;
      m_total = 0;
      m_state = 0;
   endtask

   task automatic push(int q, logic [WIDTH-1:0] d);
      sm[q][tail[q]] = d;
      tail[q] = tail[q] + 8'd1;
   endtask

   // one clock: called at a falling edge with inputs already set
   task automatic cycle();
      bit elig [NQ];
      bit any, pop, dut_pop;
      int sel, dut_sel;
      logic [WIDTH-1:0] word;
      #1;
      any = 0;
      word = '0;
      for (int q = 0; q < NQ; q++) begin
         elig[q] = (head[q] != tail[q]) && en_mask[q];
         any |= elig[q];
      end
      pop = any && (m_buf.size() < 2) && !rst;
      sel = m_cur;
      if (pop) begin
         if (elig[m_cur] && m_burst > 0 && m_burst < BURST) sel = m_cur;
         else begin
            // walk the rotation backwards so the earliest eligible queue wins
            for (int k = NQ; k >= 1; k--) if (elig[(m_cur + k) % NQ]) sel = (m_cur + k) % NQ;
         end
         word = sm[sel][head[sel]];
      end
      check("fifo_pop", fifo_pop, pop);
      check("fifo_pop_sel", fifo_pop_sel, sel);
      check("out_valid", out_valid, m_buf.size() != 0);
      if (m_buf.size() != 0) begin
         check("out_data", out_data, m_buf[0][WIDTH-1:0]);
         check("out_qid", out_qid, m_buf[0][SW+WIDTH-1:WIDTH]);
      end
      check("state", state, m_state);
      check("total_pops", total_pops, m_total);
      dut_pop = fifo_pop;
      dut_sel = fifo_pop_sel;
      if (out_valid && out_ready && !rst) acc_log.push_back({out_qid, out_data});
      if (dut_pop) sel_log.push_back(dut_sel);
      @(posedge clk);
      #1;
      if (dut_pop) head[dut_sel] = head[dut_sel] + 8'd1;
      if (rst) model_reset();
      else begin
         if (m_buf.size() != 0 && out_ready) void'(m_buf.pop_front());
         if (pop) begin
            m_buf.push_back({sel[SW-1:0], word});
            if (sel == m_cur && m_burst < BURST) m_burst++;
            else begin
               m_cur = sel;
               m_burst = 1;
            end
            m_total = (m_total + 1) % 65536;
            m_state = 1;
         end else m_state = any ? 2 : 0;
      end
      @(negedge clk);
   endtask

   task automatic reset_all();
      rst = 1'b1;
      for (int q = 0; q < NQ; q++) head[q] = tail[q];
      cycle();
      rst = 1'b0;
      sel_log.delete();
      acc_log.delete();
   endtask

   function automatic int sel_at(int i);
      return (i < sel_log.size()) ? sel_log[i] : -1;
   endfunction

   function automatic logic [SW+WIDTH-1:0] acc_at(int i);
      return (i < acc_log.size()) ? acc_log[i] : 'x;
   endfunction

   initial begin
      logic [SW+WIDTH-1:0] exp_w;
      int exp_s;
      for (int q = 0; q < NQ; q++) begin
         head[q] = 8'd0;
         tail[q] = 8'd0;
      end
      model_reset();
      repeat (2) @(negedge clk);

      // reset values, then two words from queue 0
      reset_all();
      check("rst_out_valid", out_valid, 0);
      check("rst_state", state, 0);
      check("rst_total", total_pops, 0);
      check("rst_out_data", out_data, 0);
      out_ready = 1'b1;
      push(0, 4'h3);
      push(0, 4'h5);
      repeat (6) cycle();
      check("t1_pops", sel_log.size(), 2);
      check("t1_sel0", sel_at(0), 0);
      check("t1_sel1", sel_at(1), 0);
      check("t1_acc0", acc_at(0), 5'h03);
      check("t1_acc1", acc_at(1), 5'h05);
      check("t1_total", total_pops, 2);
      check("t1_state", state, 0);

      // both queues loaded: burst-of-two alternation without bubbles
      reset_all();
      for (int i = 0; i < 4; i++) begin
         push(0, 4'(i));
         push(1, 4'(8 + i));
      end
      repeat (8) cycle();
      check("t2_pops", sel_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         exp_s = (i / 2) % 2;
         check("t2_sel", sel_at(i), exp_s);
      end
      repeat (3) cycle();
      for (int i = 0; i < 8; i++) begin
         exp_w = ((i / 2) % 2 == 0) ? {1'b0, 4'((i / 4) * 2 + i % 2)} : {1'b1, 4'(8 + (i / 4) * 2 + i % 2)};
         check("t2_acc", acc_at(i), exp_w);
      end

      // single active queue is re-granted back to back
      reset_all();
      for (int i = 0; i < 5; i++) push(1, 4'(i + 1));
      repeat (5) cycle();
      check("t3_pops", sel_log.size(), 5);
      for (int i = 0; i < 5; i++) check("t3_sel", sel_at(i), 1);
      repeat (3) cycle();

      // backpressure: two pops then stall; release pops one cycle after handshake
      reset_all();
      out_ready = 1'b0;
      push(0, 4'hA);
      push(0, 4'hB);
      push(0, 4'hC);
      repeat (4) cycle();
      check("t4_pops", sel_log.size(), 2);
      check("t4_stall", state, 2);
      check("t4_hold", out_data, 4'hA);
      out_ready = 1'b1;
      cycle();
      check("t4_no_pop_at_hs", sel_log.size(), 2);
      cycle();
      check("t4_third_pop", sel_log.size(), 3);
      repeat (3) cycle();
      check("t4_acc0", acc_at(0), 5'h0A);
      check("t4_acc1", acc_at(1), 5'h0B);
      check("t4_acc2", acc_at(2), 5'h0C);

      // enable mask: queue 1 only, then queue 0 gets the next grant
      reset_all();
      en_mask = 2'b10;
      push(0, 4'h1);
      push(0, 4'h2);
      push(1, 4'h3);
      push(1, 4'h4);
      push(1, 4'h5);
      repeat (2) cycle();
      check("t5_sel0", sel_at(0), 1);
      check("t5_sel1", sel_at(1), 1);
      en_mask = 2'b11;
      cycle();
      check("t5_sel2", sel_at(2), 0);
      repeat (6) cycle();

      // reset with a full buffer
      reset_all();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(0, 4'(i));
         push(1, 4'(i + 4));
      end
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_valid", out_valid, 0);
      check("t6_total", total_pops, 0);
      out_ready = 1'b1;
      sel_log.delete();
      cycle();
      check("t6_first_grant", sel_at(0), 0);
      repeat (8) cycle();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) en_mask = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 99) == 0);
         for (int q = 0; q < NQ; q++)
            if ($urandom_range(0, 2) == 0 && 8'(tail[q] - head[q]) < 8'd200) push(q, 4'($urandom));
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ll_fifo_drain_arbiter.md
# ll_fifo_drain_arbiter

Read-side engine for the shared linked-list FIFO. It watches the per-queue `empty` flags and drives `pop`/`pop_sel` into the shared FIFO, choosing queues round-robin with a bounded burst per queue. Popped words go into a 2-entry output buffer that presents a single valid/ready stream tagged with the source queue id. It sits between the shared FIFO's read port and the downstream consumer, and is the reader counterpart to the push-side traffic.

## Interface
- `WIDTH`, 4, data word width (matches the shared FIFO).
- `NUM_FIFOS`, 2, number of logical queues (≥2).
- `BURST`, 2, maximum consecutive pops from one queue before the arbiter must offer the grant elsewhere (≥1).
- `SEL_WIDTH`, `$clog2(NUM_FIFOS)`, width of the queue select.
- `CNT_WIDTH`, 16, width of the pop counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `en_mask`  in  NUM_FIFOS  per-queue drain enable.
- `fifo_empty`  in  NUM_FIFOS  per-queue empty flag from the shared FIFO.
- `fifo_data_out`  in  WIDTH  head word of queue `fifo_pop_sel`; combinational in `fifo_pop_sel`.
- `fifo_pop`  out  1  pop strobe to the shared FIFO.
- `fifo_pop_sel`  out  SEL_WIDTH  queue being popped or offered.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  WIDTH  output word.
- `out_qid`  out  SEL_WIDTH  source queue of `out_data`.
- `state`  out  2  debug: `IDLE`=0, `SERVE`=1, `STALL`=2.
- `total_pops`  out  CNT_WIDTH  pops issued since reset; wraps modulo 2^CNT_WIDTH.

## Operation
- A queue is eligible when its `fifo_empty` bit is 0 and its `en_mask` bit is 1.
- The buffer has space when `buf_cnt` < 2, using the registered count only. `out_ready` does not combinationally enable a pop.
- Select logic is combinational:
  - If the last grant `cur_q` is still eligible and `burst_cnt` < `BURST`, then `sel` = `cur_q`.
  - Otherwise `sel` is the first eligible queue scanning `cur_q+1, cur_q+2, …` modulo NUM_FIFOS, with `cur_q` itself checked last.
- `fifo_pop` = (any queue eligible) & space & !`rst`. `fifo_pop_sel` = `sel` when popping, otherwise `cur_q`.
- On a pop:
  - The buffer writes `{sel, fifo_data_out}`.
  - If `sel` == `cur_q` and `burst_cnt` < `BURST`, then `burst_cnt`++. Otherwise `cur_q` <= `sel` and `burst_cnt` <= 1.
  - `total_pops`++.
- When only `cur_q` is eligible and the burst is exhausted, `cur_q` is re-granted and `burst_cnt` restarts at 1. There is no idle bubble.
- State machine, updated each cycle:
  - `IDLE`: no eligible queue.
  - `STALL`: some queue is eligible but there is no space.
  - `SERVE`: a pop was issued.
- Output buffer:
  - 2-entry FIFO. `out_valid` = (`buf_cnt` != 0); `out_data`/`out_qid` come from the head entry.
  - Push and pop in the same cycle leaves `buf_cnt` unchanged.
  - Order is preserved across queues.
- `en_mask` deasserting on `cur_q` takes effect in the same cycle; the arbiter rotates.
- The block never pops an empty queue. The shared FIFO updates `empty` one cycle after a pop, so a single-entry queue is popped once and is ineligible on the next cycle.

## Timing
- Reset values:
  - `fifo_pop`=0, `out_valid`=0, `buf_cnt`=0, `burst_cnt`=0, `state`=`IDLE`, `total_pops`=0.
  - `cur_q`=NUM_FIFOS-1, so the first grant goes to queue 0.
  - `out_data`/`out_qid`=0.
- Latency: a pop in cycle t gives `out_valid`=1 in cycle t+1 with that word.
- Throughput: 1 word/cycle sustained while `out_ready`=1 (steady-state `buf_cnt`=1).
- Backpressure: with `out_ready`=0, exactly 2 pops occur, then `STALL`. The first pop after `out_ready` returns is in the cycle after the handshake.
- `rst` asserted mid-operation: buffered words are discarded, `fifo_pop`=0 in the same cycle, and all state returns to reset values on the next edge.

## Test plan
- Reset, then queue 0 holds {0x3,0x5} and queue 1 is empty, `out_ready`=1 → `fifo_pop` in cycles 1 and 2 with sel 0; out sees 0x3/qid0 then 0x5/qid0; `total_pops`=2; `state` returns to `IDLE`.
- Both queues hold 4 words, `BURST`=2, `out_ready`=1 → qid sequence 0,0,1,1,0,0,1,1 with no bubble cycles.
- Only queue 1 holds 5 words → 5 back-to-back pops with sel 1, `burst_cnt` sequence 1,2,1,2,1.
- `out_ready`=0 with 3 words available → 2 pops, `state`=`STALL`, `out_data` stable at the first word. Raise `out_ready` → the third pop happens one cycle after the first handshake, in order.
- `en_mask`=2'b10 with both queues non-empty → only queue 1 is popped. Switch to 2'b11 → queue 0 is granted next.
- `rst` pulse while `buf_cnt`=2 → `out_valid`=0 and `total_pops`=0 next cycle; the first post-reset grant goes to queue 0.
